// File: rtl/cache_arb_pkg.sv
// -----------------------------------------------------------------------------
// cache_arb_pkg
//   Shared types and constants for the cache port arbiter.
//   - arb_state_t     : arbiter FSM state (ARB = free to grant, LOCK = owner
//                       holds the cache for the duration of a miss episode)
//   - WORD_LEN        : data/address width of every port and of the cache
//   - DEFAULT_CNT_LEN : default width of the per-port performance counters
// -----------------------------------------------------------------------------
package cache_arb_pkg;

  localparam int WORD_LEN        = 32;
  localparam int DEFAULT_CNT_LEN = 32;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

endpackage : cache_arb_pkg

// File: rtl/cache_port_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin priority picker. Returns the first requesting
//   port found when scanning upward from last_grant+1, wrapping at NUM_PORTS.
//   Ports:
//     req_vec    in   NUM_PORTS  one bit per requesting port
//     last_grant in   PORT_LEN   index of the most recently completed port
//     grant      out  PORT_LEN   winning port index (0 when nobody requests)
//     any_req    out  1          at least one port is requesting
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int NUM_PORTS = 2,
  parameter int PORT_LEN  = 1
) (
  input  logic [NUM_PORTS-1:0] req_vec,
  input  logic [PORT_LEN-1:0]  last_grant,
  output logic [PORT_LEN-1:0]  grant,
  output logic                 any_req
);

  // cand_idx[k] is the port sitting k+1 places after last_grant. One extra
  // bit on the sum keeps the wrap test exact for any NUM_PORTS.
  logic [NUM_PORTS-1:0][PORT_LEN-1:0] cand_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_cand
      logic [PORT_LEN:0] sum;
      assign sum = {1'b0, last_grant} + (PORT_LEN+1)'(gi + 1);
      assign cand_idx[gi] = (sum >= (PORT_LEN+1)'(NUM_PORTS))
                          ? PORT_LEN'(sum - (PORT_LEN+1)'(NUM_PORTS))
                          : PORT_LEN'(sum);
    end
  endgenerate

  // Walk from the farthest candidate to the nearest so the closest requester
  // after last_grant overwrites everything else.
  always_comb begin
    grant = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (req_vec[cand_idx[k]]) begin
        grant = cand_idx[k];
      end
    end
  end

  assign any_req = |req_vec;

endmodule : rr_pick

// File: rtl/cache_port_arbiter.sv
// -----------------------------------------------------------------------------
// cache_port_arbiter
//   Shares one blocking data cache between NUM_PORTS pipeline requesters.
//   One request per cycle is forwarded to the cache with zero added latency.
//   A port that misses keeps ownership of the cache until the miss resolves
//   (or the port withdraws its request), then arbitration resumes round-robin.
//   Read data returns one cycle after completion with a per-port valid strobe.
//   Ports:
//     clk, rst     clock, asynchronous active-high reset
//     p_rd_req     per-port read request
//     p_wr_req     per-port write request (ignored when p_rd_req is also set)
//     p_addr       per-port byte address, port i at [32i+31:32i]
//     p_wr_data    per-port write data, same packing
//     p_done       combinational: the port's request was accepted this cycle
//     p_rd_valid   registered: p_rd_data belongs to this port this cycle
//     p_rd_data    shared read data (straight from the cache)
//     c_addr, c_rd_req, c_wr_req, c_wr_data   request to the cache
//     c_miss       cache miss / busy
//     c_rd_data    cache read data (registered inside the cache)
//     cnt_access   completed accesses per port
//     cnt_miss     miss episodes per port
// -----------------------------------------------------------------------------
module cache_port_arbiter
  import cache_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int PORT_LEN  = 1,
  parameter int CNT_LEN   = DEFAULT_CNT_LEN
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS-1:0]           p_rd_req,
  input  logic [NUM_PORTS-1:0]           p_wr_req,
  input  logic [NUM_PORTS*WORD_LEN-1:0]  p_addr,
  input  logic [NUM_PORTS*WORD_LEN-1:0]  p_wr_data,
  output logic [NUM_PORTS-1:0]           p_done,
  output logic [NUM_PORTS-1:0]           p_rd_valid,
  output logic [WORD_LEN-1:0]            p_rd_data,
  output logic [WORD_LEN-1:0]            c_addr,
  output logic                           c_rd_req,
  output logic                           c_wr_req,
  output logic [WORD_LEN-1:0]            c_wr_data,
  input  logic                           c_miss,
  input  logic [WORD_LEN-1:0]            c_rd_data,
  output logic [NUM_PORTS*CNT_LEN-1:0]   cnt_access,
  output logic [NUM_PORTS*CNT_LEN-1:0]   cnt_miss
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  arb_state_t           state_reg, state_next;
  logic [PORT_LEN-1:0]  last_grant_reg, last_grant_next;
  logic [PORT_LEN-1:0]  owner_reg, owner_next;
  logic [NUM_PORTS-1:0] rd_valid_reg, rd_valid_next;

  // The packed 2-D view lines up with the flat port buses bit for bit.
  logic [NUM_PORTS-1:0][WORD_LEN-1:0] addr_arr;
  logic [NUM_PORTS-1:0][WORD_LEN-1:0] wr_data_arr;
  assign addr_arr    = p_addr;
  assign wr_data_arr = p_wr_data;

  logic [NUM_PORTS-1:0] req_vec;
  logic [PORT_LEN-1:0]  pick_idx;
  logic                 any_req;
  assign req_vec = p_rd_req | p_wr_req;

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_LEN  (PORT_LEN)
  ) u_rr_pick (
    .req_vec    (req_vec),
    .last_grant (last_grant_reg),
    .grant      (pick_idx),
    .any_req    (any_req)
  );

  // ---------------------------------------------------------------------------
  // Port selection: the round-robin winner in ARB, the owner in LOCK. Kept
  // apart from the FSM block so the one-hot decode is a plain feed-forward.
  // ---------------------------------------------------------------------------
  logic [PORT_LEN-1:0]  sel;
  logic                 sel_active;
  logic [NUM_PORTS-1:0] sel_onehot;

  always_comb begin
    sel        = pick_idx;
    sel_active = any_req;
    if (state_reg == LOCK) begin
      sel        = owner_reg;
      sel_active = req_vec[owner_reg];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_onehot
      assign sel_onehot[gi] = (sel == PORT_LEN'(gi));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // FSM next-state and cache-side outputs
  // ---------------------------------------------------------------------------
  logic sel_rd, sel_wr, miss_start;

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    owner_next      = owner_reg;
    rd_valid_next   = '0;
    miss_start      = 1'b0;
    p_done          = '0;

    // A simultaneous read and write is illegal; the read wins.
    sel_rd = sel_active & p_rd_req[sel];
    sel_wr = sel_active & p_wr_req[sel] & ~p_rd_req[sel];

    c_rd_req  = sel_rd;
    c_wr_req  = sel_wr;
    c_addr    = sel_active ? addr_arr[sel]    : '0;
    c_wr_data = sel_active ? wr_data_arr[sel] : '0;

    if (sel_active && !c_miss) begin
      // Accepted by the cache: complete and let arbitration move on.
      p_done          = sel_onehot;
      last_grant_next = sel;
      state_next      = ARB;
      if (sel_rd) begin
        rd_valid_next = sel_onehot;
      end
    end else if (sel_active) begin
      // Miss: lock the cache to this port until it is serviced. A miss seen
      // while already locked is the same episode, so it is not recounted.
      if (state_reg == ARB) begin
        state_next = LOCK;
        owner_next = sel;
        miss_start = 1'b1;
      end
    end else if (state_reg == LOCK) begin
      // Owner withdrew (pipeline flush). The cache finishes its refill on its
      // own and keeps c_miss high for whoever asks next.
      state_next = ARB;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ARB;
      last_grant_reg <= PORT_LEN'(NUM_PORTS - 1);
      owner_reg      <= '0;
      rd_valid_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      owner_reg      <= owner_next;
      rd_valid_reg   <= rd_valid_next;
    end
  end

  // The cache registers its read data, so it lines up with rd_valid_reg.
  assign p_rd_valid = rd_valid_reg;
  assign p_rd_data  = c_rd_data;

  // ---------------------------------------------------------------------------
  // Per-port performance counters (wrap naturally)
  // ---------------------------------------------------------------------------
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_cnt
      logic [CNT_LEN-1:0] access_reg;
      logic [CNT_LEN-1:0] miss_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          access_reg <= '0;
          miss_reg   <= '0;
        end else begin
          if (p_done[gi]) begin
            access_reg <= access_reg + CNT_LEN'(1);
          end
          if (miss_start && sel_onehot[gi]) begin
            miss_reg <= miss_reg + CNT_LEN'(1);
          end
        end
      end

      assign cnt_access[gi*CNT_LEN +: CNT_LEN] = access_reg;
      assign cnt_miss[gi*CNT_LEN +: CNT_LEN]   = miss_reg;
    end
  endgenerate

endmodule : cache_port_arbiter

// File: tb/tb_cache_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_port_arbiter
//   Bench for cache_port_arbiter with a small blocking-cache model attached
//   to the cache side. Directed scenarios are followed by a randomized run
//   checked cycle by cycle against a behavioural reference model.
// -----------------------------------------------------------------------------
module tb_cache_port_arbiter;

  localparam int N        = 2;
  localparam int PL       = 1;
  localparam int CL       = 32;
  localparam int MISS_LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    p_rd_req, p_wr_req, p_done, p_rd_valid;
  logic [N*32-1:0] p_addr, p_wr_data;
  logic [31:0]     p_rd_data, c_addr, c_wr_data, c_rd_data;
  logic            c_rd_req, c_wr_req, c_miss;
  logic [N*CL-1:0] cnt_access, cnt_miss;

  cache_port_arbiter #(
    .NUM_PORTS (N),
    .PORT_LEN  (PL),
    .CNT_LEN   (CL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .p_rd_req   (p_rd_req),
    .p_wr_req   (p_wr_req),
    .p_addr     (p_addr),
    .p_wr_data  (p_wr_data),
    .p_done     (p_done),
    .p_rd_valid (p_rd_valid),
    .p_rd_data  (p_rd_data),
    .c_addr     (c_addr),
    .c_rd_req   (c_rd_req),
    .c_wr_req   (c_wr_req),
    .c_wr_data  (c_wr_data),
    .c_miss     (c_miss),
    .c_rd_data  (c_rd_data),
    .cnt_access (cnt_access),
    .cnt_miss   (cnt_miss)
  );

  // ---------------------------------------------------------------------------
  // Blocking cache model: 64-byte lines, a miss refills for MISS_LAT cycles
  // during which every request sees c_miss. Words never written read back
  // as fill_word(addr).
  // ---------------------------------------------------------------------------
  function automatic bit [31:0] fill_word(input bit [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[15:0]};
  endfunction

  bit [31:0]   mem [0:4095];
  bit [4095:0] written;
  logic [255:0] cached;
  logic        busy;
  int          swap_cnt;
  logic [7:0]  swap_line;
  bit [31:0]   rd_data_r;
  logic        prime_en = 1'b0;
  logic [7:0]  prime_line = 8'd0;

  assign c_rd_data = rd_data_r;
  assign c_miss = busy || ((c_rd_req || c_wr_req) && !cached[c_addr[13:6]]);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      cached   <= '0;
      swap_cnt <= 0;
    end else if (prime_en) begin
      cached[prime_line] <= 1'b1;
    end else if (busy) begin
      if (swap_cnt == 1) begin
        busy              <= 1'b0;
        cached[swap_line] <= 1'b1;
      end
      swap_cnt <= swap_cnt - 1;
    end else if (c_rd_req || c_wr_req) begin
      if (!cached[c_addr[13:6]]) begin
        busy      <= 1'b1;
        swap_cnt  <= MISS_LAT;
        swap_line <= c_addr[13:6];
      end else begin
        if (c_wr_req) begin
          mem[c_addr[13:2]]     <= c_wr_data;
          written[c_addr[13:2]] <= 1'b1;
        end
        if (c_rd_req) begin
          rd_data_r <= written[c_addr[13:2]] ? mem[c_addr[13:2]] : fill_word(c_addr);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bookkeeping and reference state
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  int          m_last;
  int          m_owner;      // -1 when nobody holds the cache
  bit [N-1:0]  m_valid;
  bit [31:0]   m_data;
  int unsigned m_acc  [N];
  int unsigned m_miss [N];
  bit [31:0]   gold [bit [31:0]];

  function automatic bit [31:0] acc_of(input int i);
    return cnt_access[i*CL +: CL];
  endfunction

  function automatic bit [31:0] miss_of(input int i);
    return cnt_miss[i*CL +: CL];
  endfunction

  task automatic model_init();
    m_last  = N - 1;
    m_owner = -1;
    m_valid = '0;
    m_data  = '0;
    for (int i = 0; i < N; i++) begin
      m_acc[i]  = 0;
      m_miss[i] = 0;
    end
  endtask

  task automatic set_port(input int i, input bit rd, input bit wr,
                          input bit [31:0] a, input bit [31:0] d);
    p_rd_req[i]          = rd;
    p_wr_req[i]          = wr;
    p_addr[i*32 +: 32]   = a;
    p_wr_data[i*32 +: 32] = d;
  endtask

  task automatic clear_inputs();
    p_rd_req  = '0;
    p_wr_req  = '0;
    p_addr    = '0;
    p_wr_data = '0;
  endtask

  // Leaves the bench at posedge+1 with the DUT freshly reset.
  task automatic do_reset();
    clear_inputs();
    prime_en = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_init();
  endtask

  task automatic prime(input bit [31:0] a);
    prime_line = a[13:6];
    prime_en   = 1'b1;
    @(posedge clk);
    #1;
    prime_en = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    clear_inputs();
    set_port(0, 1'b1, 1'b0, 32'h40, 32'h0);
    set_port(1, 1'b1, 1'b0, 32'h80, 32'h0);
    rst = 1'b1;
    #1;
    n_checks++;
    if (p_rd_valid !== 2'b00) $display("FAIL reset_rd_valid: got %b expected 00", p_rd_valid);
    n_checks++;
    if (cnt_access !== '0 || cnt_miss !== '0)
      begin n_fail++; $display("FAIL reset_counters: got access %h miss %h expected 0", cnt_access, cnt_miss); end
    n_checks++;
    if (c_addr !== 32'h40 || c_rd_req !== 1'b1)
      begin n_fail++; $display("FAIL reset_first_winner: got addr %h rd %b expected 00000040 1", c_addr, c_rd_req); end
    if (p_rd_valid !== 2'b00) n_fail++;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (c_addr !== 32'h40 || p_done !== 2'b00)
      begin n_fail++; $display("FAIL reset_hold_arb: got addr %h done %b expected 00000040 00", c_addr, p_done); end
    clear_inputs();
    rst = 1'b0;
    model_init();
    @(posedge clk);
    #1;
    n_checks++;
    if (p_rd_valid !== 2'b00 || cnt_access !== '0)
      begin n_fail++; $display("FAIL reset_release_idle: got valid %b access %h expected 00 0", p_rd_valid, cnt_access); end
  endtask

  task automatic test_single_hit();
    do_reset();
    prime(32'h40);
    set_port(0, 1'b1, 1'b0, 32'h40, 32'h0);
    #1;
    n_checks++;
    if (p_done !== 2'b01 || c_addr !== 32'h40 || c_rd_req !== 1'b1 || c_wr_req !== 1'b0)
      begin n_fail++; $display("FAIL hit_done: got done %b addr %h rd %b wr %b expected 01 00000040 1 0", p_done, c_addr, c_rd_req, c_wr_req); end
    @(posedge clk);
    #1;
    clear_inputs();
    #1;
    n_checks++;
    if (p_rd_valid !== 2'b01 || p_rd_data !== fill_word(32'h40))
      begin n_fail++; $display("FAIL hit_rd_return: got valid %b data %h expected 01 %h", p_rd_valid, p_rd_data, fill_word(32'h40)); end
    n_checks++;
    if (acc_of(0) !== 32'd1 || acc_of(1) !== 32'd0 || miss_of(0) !== 32'd0)
      begin n_fail++; $display("FAIL hit_counters: got acc0 %0d acc1 %0d miss0 %0d expected 1 0 0", acc_of(0), acc_of(1), miss_of(0)); end
    @(posedge clk);
    #2;
    n_checks++;
    if (p_rd_valid !== 2'b00)
      begin n_fail++; $display("FAIL hit_valid_one_cycle: got %b expected 00", p_rd_valid); end
  endtask

  task automatic test_contention();
    bit [N-1:0] exp_done;
    do_reset();
    prime(32'h80);
    prime(32'hC0);
    set_port(0, 1'b1, 1'b0, 32'h80, 32'h0);
    set_port(1, 1'b1, 1'b0, 32'hC0, 32'h0);
    for (int k = 0; k < 6; k++) begin
      exp_done = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      n_checks++;
      if (p_done !== exp_done)
        begin n_fail++; $display("FAIL contention_grant[%0d]: got %b expected %b", k, p_done, exp_done); end
      @(posedge clk);
      #1;
    end
    clear_inputs();
    #1;
    n_checks++;
    if (acc_of(0) !== 32'd3 || acc_of(1) !== 32'd3)
      begin n_fail++; $display("FAIL contention_counts: got %0d %0d expected 3 3", acc_of(0), acc_of(1)); end
  endtask

  task automatic test_miss_lock();
    bit got;
    do_reset();
    prime(32'h40);
    set_port(1, 1'b1, 1'b0, 32'h2000, 32'h0);
    #1;
    n_checks++;
    if (c_addr !== 32'h2000 || p_done !== 2'b00)
      begin n_fail++; $display("FAIL miss_start: got addr %h done %b expected 00002000 00", c_addr, p_done); end
    @(posedge clk);
    #1;
    set_port(0, 1'b1, 1'b0, 32'h40, 32'h0);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      #1;
      n_checks++;
      if (c_addr !== 32'h2000)
        begin n_fail++; $display("FAIL miss_addr_held[%0d]: got %h expected 00002000", k, c_addr); end
      if (p_done !== 2'b00) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    n_checks++;
    if (!got || p_done !== 2'b10)
      begin n_fail++; $display("FAIL miss_owner_done: got %b (seen %0d) expected 10", p_done, got); end
    @(posedge clk);
    #1;
    set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    n_checks++;
    if (p_done !== 2'b01 || c_addr !== 32'h40)
      begin n_fail++; $display("FAIL miss_next_grant: got done %b addr %h expected 01 00000040", p_done, c_addr); end
    n_checks++;
    if (p_rd_valid !== 2'b10 || p_rd_data !== fill_word(32'h2000))
      begin n_fail++; $display("FAIL miss_rd_return: got valid %b data %h expected 10 %h", p_rd_valid, p_rd_data, fill_word(32'h2000)); end
    n_checks++;
    if (miss_of(1) !== 32'd1 || miss_of(0) !== 32'd0)
      begin n_fail++; $display("FAIL miss_counter: got miss1 %0d miss0 %0d expected 1 0", miss_of(1), miss_of(0)); end
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic test_write_read();
    do_reset();
    prime(32'h100);
    set_port(0, 1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF);
    #1;
    n_checks++;
    if (p_done !== 2'b01 || c_wr_req !== 1'b1 || c_rd_req !== 1'b0 || c_wr_data !== 32'hDEAD_BEEF)
      begin n_fail++; $display("FAIL wr_issue: got done %b wr %b rd %b data %h expected 01 1 0 deadbeef", p_done, c_wr_req, c_rd_req, c_wr_data); end
    @(posedge clk);
    #1;
    set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_port(1, 1'b1, 1'b0, 32'h100, 32'h0);
    #1;
    n_checks++;
    if (p_rd_valid !== 2'b00)
      begin n_fail++; $display("FAIL wr_no_valid: got %b expected 00", p_rd_valid); end
    n_checks++;
    if (p_done !== 2'b10)
      begin n_fail++; $display("FAIL rd_after_wr_done: got %b expected 10", p_done); end
    @(posedge clk);
    #1;
    clear_inputs();
    #1;
    n_checks++;
    if (p_rd_valid !== 2'b10 || p_rd_data !== 32'hDEAD_BEEF)
      begin n_fail++; $display("FAIL rd_after_wr_data: got valid %b data %h expected 10 deadbeef", p_rd_valid, p_rd_data); end
  endtask

  task automatic test_flush();
    bit got;
    int waited;
    do_reset();
    prime(32'h40);
    set_port(1, 1'b1, 1'b0, 32'h3000, 32'h0);
    #1;
    n_checks++;
    if (p_done !== 2'b00 || c_addr !== 32'h3000)
      begin n_fail++; $display("FAIL flush_miss: got done %b addr %h expected 00 00003000", p_done, c_addr); end
    @(posedge clk);
    #1;
    set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
    set_port(0, 1'b1, 1'b0, 32'h40, 32'h0);
    #1;
    // Still locked on port 1 this cycle: port 0 must not reach the cache.
    n_checks++;
    if (p_done !== 2'b00 || c_rd_req !== 1'b0 || c_wr_req !== 1'b0)
      begin n_fail++; $display("FAIL flush_lock_cycle: got done %b rd %b wr %b expected 00 0 0", p_done, c_rd_req, c_wr_req); end
    got = 1'b0;
    waited = 0;
    while (!got && waited < 20) begin
      @(posedge clk);
      #2;
      waited++;
      n_checks++;
      if (p_done[1] !== 1'b0)
        begin n_fail++; $display("FAIL flush_no_done1[%0d]: got %b expected 0", waited, p_done[1]); end
      if (p_done[0] === 1'b1) got = 1'b1;
    end
    n_checks++;
    if (!got || waited != MISS_LAT)
      begin n_fail++; $display("FAIL flush_p0_grant: got granted %0d after %0d cycles expected 1 after %0d", got, waited, MISS_LAT); end
    @(posedge clk);
    #1;
    clear_inputs();
    #1;
    n_checks++;
    if (miss_of(1) !== 32'd1 || acc_of(1) !== 32'd0 || acc_of(0) !== 32'd1)
      begin n_fail++; $display("FAIL flush_counters: got miss1 %0d acc1 %0d acc0 %0d expected 1 0 1", miss_of(1), acc_of(1), acc_of(0)); end
  endtask

  task automatic test_reset_mid_lock();
    bit got;
    do_reset();
    set_port(1, 1'b1, 1'b0, 32'h2000, 32'h0);
    @(posedge clk);
    #2;
    n_checks++;
    if (miss_of(1) !== 32'd1)
      begin n_fail++; $display("FAIL rml_pre_miss: got %0d expected 1", miss_of(1)); end
    set_port(0, 1'b1, 1'b0, 32'h40, 32'h0);
    #1;
    n_checks++;
    if (c_addr !== 32'h2000)
      begin n_fail++; $display("FAIL rml_locked_owner: got %h expected 00002000", c_addr); end
    // Asynchronous reset, well away from any clock edge.
    rst = 1'b1;
    #1;
    n_checks++;
    if (cnt_miss !== '0 || cnt_access !== '0 || p_rd_valid !== 2'b00)
      begin n_fail++; $display("FAIL rml_async_clear: got miss %h access %h valid %b expected 0 0 00", cnt_miss, cnt_access, p_rd_valid); end
    n_checks++;
    if (c_addr !== 32'h40)
      begin n_fail++; $display("FAIL rml_back_to_arb: got %h expected 00000040", c_addr); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_init();
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      #1;
      if (p_done !== 2'b00) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    n_checks++;
    if (!got || p_done !== 2'b01)
      begin n_fail++; $display("FAIL rml_first_grant: got %b (seen %0d) expected 01", p_done, got); end
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  // Random traffic against the reference model. Ports hold a request until
  // it completes, occasionally withdraw it (flush) and occasionally raise
  // read and write together.
  task automatic test_random();
    bit          act  [N];
    bit          a_rd [N];
    bit          a_both [N];
    bit [31:0]   a_adr [N];
    bit [31:0]   a_dat [N];
    int          sel, j;
    bit          act_m, rd_m, wr_m;
    bit [N-1:0]  exp_done;
    bit [31:0]   key;
    do_reset();
    gold.delete();
    for (int i = 0; i < N; i++) act[i] = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (act[i] && $urandom_range(0, 24) == 0) begin
          act[i] = 1'b0;
        end else if (!act[i] && $urandom_range(0, 2) != 0) begin
          act[i]    = 1'b1;
          a_rd[i]   = ($urandom_range(0, 2) != 0);
          a_both[i] = a_rd[i] && ($urandom_range(0, 9) == 0);
          a_adr[i]  = 32'h1000 | (32'($urandom_range(0, 7)) << 6) | (32'($urandom_range(0, 15)) << 2);
          a_dat[i]  = $urandom;
        end
        set_port(i, act[i] && a_rd[i], act[i] && (!a_rd[i] || a_both[i]),
                 act[i] ? a_adr[i] : 32'h0, a_dat[i]);
      end
      #1;
      // Who should be talking to the cache this cycle.
      sel = -1;
      if (m_owner >= 0) begin
        sel   = m_owner;
        act_m = p_rd_req[sel] || p_wr_req[sel];
      end else begin
        for (int k = 1; k <= N; k++) begin
          j = (m_last + k) % N;
          if (sel < 0 && (p_rd_req[j] || p_wr_req[j])) sel = j;
        end
        act_m = (sel >= 0);
      end
      rd_m = act_m && p_rd_req[sel];
      wr_m = act_m && p_wr_req[sel] && !p_rd_req[sel];
      exp_done = (act_m && !c_miss) ? (N'(1) << sel) : '0;

      n_checks++;
      if (p_done !== exp_done)
        begin n_fail++; $display("FAIL rnd_done[%0d]: got %b expected %b", cyc, p_done, exp_done); end
      n_checks++;
      if ({c_rd_req, c_wr_req} !== {rd_m, wr_m})
        begin n_fail++; $display("FAIL rnd_req[%0d]: got rd %b wr %b expected %b %b", cyc, c_rd_req, c_wr_req, rd_m, wr_m); end
      if (act_m || m_owner < 0) begin
        n_checks++;
        if (c_addr !== (act_m ? p_addr[sel*32 +: 32] : 32'h0))
          begin n_fail++; $display("FAIL rnd_addr[%0d]: got %h expected %h", cyc, c_addr, act_m ? p_addr[sel*32 +: 32] : 32'h0); end
      end
      n_checks++;
      if (p_rd_valid !== m_valid)
        begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b expected %b", cyc, p_rd_valid, m_valid); end
      if (m_valid != '0) begin
        n_checks++;
        if (p_rd_data !== m_data)
          begin n_fail++; $display("FAIL rnd_rdata[%0d]: got %h expected %h", cyc, p_rd_data, m_data); end
      end

      // Advance the reference model.
      m_valid = '0;
      if (act_m && !c_miss) begin
        key = p_addr[sel*32 +: 32] & 32'h3FFC;
        m_acc[sel]++;
        m_last  = sel;
        m_owner = -1;
        if (rd_m) begin
          m_valid = N'(1) << sel;
          m_data  = gold.exists(key) ? gold[key] : fill_word(key);
        end else begin
          gold[key] = p_wr_data[sel*32 +: 32];
        end
        act[sel] = 1'b0;
      end else if (act_m) begin
        if (m_owner < 0) begin
          m_owner = sel;
          m_miss[sel]++;
        end
      end else begin
        m_owner = -1;
      end
      @(posedge clk);
      #1;
    end
    clear_inputs();
    #1;
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (acc_of(i) !== m_acc[i] || miss_of(i) !== m_miss[i])
        begin n_fail++; $display("FAIL rnd_counters[%0d]: got acc %0d miss %0d expected %0d %0d", i, acc_of(i), miss_of(i), m_acc[i], m_miss[i]); end
    end
  endtask

  initial begin
    clear_inputs();
    #1;
    test_reset();
    test_single_hit();
    test_contention();
    test_miss_lock();
    test_write_read();
    test_flush();
    test_reset_mid_lock();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_cache_port_arbiter
